// File: rtl/cb_seg_engine.sv
// cb_seg_engine: LTE code-block segmentation with filler and per-CB CRC24B.
// Define CB_CRC_ATTACH_EN to compute CRC24B; otherwise the CRC slot carries zeros.
module cb_seg_engine #(
  parameter int Z   = 6144,
  parameter int L   = 24,
  parameter int B_W = 17,
  parameter int C_W = 6,
  parameter int K_W = 13
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [B_W-1:0] tb_size_in,
  input  logic           wreq_size,
  output logic           size_ready,
  input  logic           tb_in,
  input  logic           wreq_data,
  output logic           tb_ready,
  output logic           cb_data,
  output logic           cb_valid,
  input  logic           cb_ready,
  output logic           start,
  output logic           stop,
  output logic           filling,
  output logic           crc,
  output logic           cb_size,
  output logic [K_W-1:0] cb_len,
  output logic [C_W-1:0] cb_num,
  output logic           busy,
  output logic           err
);
  localparam int D_W = B_W + 1;
  localparam int P_W = C_W + K_W;
  localparam int N_CALC = 2 * B_W + 4;
  localparam int T_W = $clog2(N_CALC);
  localparam logic [31:0] B_MAX = 32'((2**C_W - 1) * (Z - L));
  localparam logic [B_W-1:0] Z_B = B_W'(Z);
  localparam logic [D_W-1:0] ZL_D = D_W'(Z - L);
  localparam logic [K_W-1:0] ZL_K = K_W'(Z - L);
  localparam logic [D_W-1:0] L_D = D_W'(L);
  localparam logic [K_W-1:0] L_K = K_W'(L);
  localparam logic [K_W-1:0] K_MIN = K_W'(40);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]     state_q;
  logic [T_W-1:0] cyc_q;
  logic [B_W-1:0] b_q;
  logic [D_W-1:0] bp_q, q_q;
  logic [K_W-1:0] rem_q, dvs_q;
  logic [C_W-1:0] c_q, cm_q, r_q;
  logic [K_W-1:0] kp_q, km_q, f_q, pos_q;
  logic           err_q;

  function automatic logic [2:0] grid_sh(input logic [K_W-1:0] k);
    logic [2:0] s;
    s = 3'd6;
    unique case (1'b1)
      k <= K_W'(512):                    s = 3'd3;
      k > K_W'(512) && k <= K_W'(1024):  s = 3'd4;
      k > K_W'(1024) && k <= K_W'(2048): s = 3'd5;
      k > K_W'(2048):                    s = 3'd6;
    endcase
    return s;
  endfunction

  // one restoring-division step shared by both divisions
  logic [K_W:0] rem_sh;
  logic         ge;
  assign rem_sh = {rem_q, q_q[D_W-1]};
  assign ge = rem_sh >= {1'b0, dvs_q};

  logic           big;
  logic [C_W-1:0] c_n;
  logic [D_W-1:0] bp_n;
  assign big = b_q > Z_B;
  assign c_n = big ? q_q[C_W-1:0] : C_W'(1);
  assign bp_n = big ? D_W'(b_q) + D_W'(c_n) * L_D : D_W'(b_q);

  logic [K_W-1:0] kr, mask, kp_raw, kp_n, kp_m1, km_n, f_n;
  logic [2:0]     sh_r, sh_m;
  logic [P_W-1:0] ckp, diff;
  logic [C_W-1:0] cm_n;
  logic           multi;
  assign multi = c_q > C_W'(1);
  assign kr = q_q[K_W-1:0];
  assign sh_r = grid_sh(kr);
  assign mask = (K_W'(1) << sh_r) - K_W'(1);
  assign kp_raw = (kr + mask) & ~mask;
  assign kp_n = (kp_raw < K_MIN) ? K_MIN : kp_raw;
  assign kp_m1 = kp_n - K_W'(1);
  assign sh_m = grid_sh(kp_m1);
  assign km_n = multi ? kp_n - (K_W'(1) << sh_m) : '0;
  assign ckp = P_W'(c_q) * P_W'(kp_n);
  assign diff = ckp - P_W'(bp_q);
  assign cm_n = multi ? C_W'(diff >> sh_m) : '0;
  assign f_n = K_W'(diff - (P_W'(cm_n) << sh_m));

  logic           is_str, in_fill, in_crc, in_data, last, acc, crc_bit;
  logic [K_W-1:0] cur_len, fill_len, crc_at;
  assign is_str = state_q == S_STREAM;
  assign cur_len = (r_q < cm_q) ? km_q : kp_q;
  assign fill_len = (r_q == '0) ? f_q : '0;
  assign crc_at = multi ? cur_len - L_K : cur_len;
  assign in_fill = pos_q < fill_len;
  assign in_crc = pos_q >= crc_at;
  assign in_data = !in_fill && !in_crc;
  assign last = pos_q == cur_len - K_W'(1);
  assign acc = cb_valid && cb_ready;

  logic bad_size;
  assign bad_size = (tb_size_in == '0) || (32'(tb_size_in) > B_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q <= '0;
      b_q <= '0;
      bp_q <= '0;
      q_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      c_q <= '0;
      cm_q <= '0;
      r_q <= '0;
      kp_q <= '0;
      km_q <= '0;
      f_q <= '0;
      pos_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (wreq_size) begin
          if (bad_size) begin
            err_q <= 1'b1;
          end else begin
            state_q <= S_CALC;
            b_q <= tb_size_in;
            cyc_q <= '0;
            q_q <= D_W'(tb_size_in) + ZL_D - D_W'(1);
            rem_q <= '0;
            dvs_q <= ZL_K;
          end
        end
        S_CALC: begin
          cyc_q <= cyc_q + T_W'(1);
          if (cyc_q == T_W'(D_W)) begin
            c_q <= c_n;
            bp_q <= bp_n;
            q_q <= bp_n + D_W'(c_n) - D_W'(1);
            rem_q <= '0;
            dvs_q <= K_W'(c_n);
          end else if (cyc_q == T_W'(N_CALC - 1)) begin
            kp_q <= kp_n;
            km_q <= km_n;
            cm_q <= cm_n;
            f_q <= f_n;
            r_q <= '0;
            pos_q <= '0;
            state_q <= S_STREAM;
          end else begin
            rem_q <= K_W'(ge ? rem_sh - {1'b0, dvs_q} : rem_sh);
            q_q <= {q_q[D_W-2:0], ge};
          end
        end
        S_STREAM: if (acc) begin
          if (last) begin
            pos_q <= '0;
            if (r_q == c_q - C_W'(1)) state_q <= S_IDLE;
            else r_q <= r_q + C_W'(1);
          end else begin
            pos_q <= pos_q + K_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CB_CRC_ATTACH_EN
  localparam logic [L-1:0] POLY = L'(24'h800063);
  logic [L-1:0] crc_q;
  logic         fb;
  assign fb = crc_q[L-1] ^ (in_data & tb_in);
  always_ff @(posedge clk) begin
    if (!rst_n || !is_str) crc_q <= '0;
    else if (acc) begin
      if (last) crc_q <= '0;
      else if (in_crc) crc_q <= {crc_q[L-2:0], 1'b0};
      else crc_q <= {crc_q[L-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end
  assign crc_bit = crc_q[L-1];
`else
  assign crc_bit = 1'b0;
`endif

  assign size_ready = state_q == S_IDLE;
  assign busy = state_q != S_IDLE;
  assign err = err_q;
  assign cb_num = c_q;
  assign cb_valid = is_str && (in_data ? wreq_data : 1'b1);
  assign tb_ready = is_str && in_data && cb_ready;
  assign cb_data = is_str && (in_data ? tb_in : (in_crc && crc_bit));
  assign start = is_str && (pos_q == '0);
  assign stop = is_str && last;
  assign filling = is_str && in_fill;
  assign crc = is_str && in_crc;
  assign cb_size = is_str && (r_q >= cm_q);
  assign cb_len = is_str ? cur_len : '0;
endmodule

// File: tb/tb_cb_seg_engine.sv
// tb_cb_seg_engine: random-stimulus bench against a table-search segmentation
// model with long-division CRC24B reference.
module tb_cb_seg_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] tb_size_in;
  logic        wreq_size, size_ready, tb_in, wreq_data, tb_ready;
  logic        cb_data, cb_valid, cb_ready, start, stop, filling, crc;
  logic        cb_size, busy, err;
  logic [12:0] cb_len;
  logic [5:0]  cb_num;

  cb_seg_engine dut (
    .clk(clk), .rst_n(rst_n), .tb_size_in(tb_size_in),
    .wreq_size(wreq_size), .size_ready(size_ready), .tb_in(tb_in),
    .wreq_data(wreq_data), .tb_ready(tb_ready), .cb_data(cb_data),
    .cb_valid(cb_valid), .cb_ready(cb_ready), .start(start), .stop(stop),
    .filling(filling), .crc(crc), .cb_size(cb_size), .cb_len(cb_len),
    .cb_num(cb_num), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d, st, sp, fl, cr, sz;
    logic [12:0] len;
  } rec_t;

  int vectors = 0;
  int errors = 0;
  bit tbits [0:19999];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_k(input int k);
    int s;
    if (k < 40 || k > 6144) return 1'b0;
    s = (k <= 512) ? 8 : (k <= 1024) ? 16 : (k <= 2048) ? 32 : 64;
    return (k % s) == 0;
  endfunction

  // table search: smallest legal K covering B'/C, next smaller legal K
  function automatic void seg(input int b, output int c, output int kp,
                              output int km, output int cp, output int cm,
                              output int f);
    int bp;
    if (b <= 6144) begin
      c = 1;
      bp = b;
    end else begin
      c = (b + 6119) / 6120;
      bp = b + c * 24;
    end
    kp = 40;
    while (!(is_k(kp) && c * kp >= bp)) kp++;
    if (c == 1) begin
      km = 0;
      cm = 0;
      cp = 1;
    end else begin
      km = kp - 1;
      while (!is_k(km)) km--;
      cm = (c * kp - bp) / (kp - km);
      cp = c - cm;
    end
    f = cp * kp + cm * km - bp;
  endfunction

  task automatic run_tb(input int b, input bit stall, input int abort_at);
    int c, kp, km, cp, cm, f, n, idx, got, cyc, budget;
    rec_t q[$];
    rec_t act;
    logic [24:0] g;
    bit v [0:6300];
    bit m [0:6300];
    g = 25'h1800063;
    for (int i = 0; i < b; i++) tbits[i] = 1'($urandom_range(0, 1));
    seg(b, c, kp, km, cp, cm, f);
    n = 0;
    for (int r = 0; r < c; r++) begin
      int len, nf, nm;
      rec_t e;
      len = (r < cm) ? km : kp;
      nf = (r == 0) ? f : 0;
      nm = len - ((c > 1) ? 24 : 0);
      for (int i = 0; i < nm + 24; i++) begin
        v[i] = (i < nf || i >= nm) ? 1'b0 : tbits[n + i - nf];
        m[i] = v[i];
      end
      for (int i = 0; i < nm; i++)
        if (v[i]) for (int j = 0; j < 25; j++) v[i + j] ^= g[24 - j];
      for (int i = 0; i < len; i++) begin
        e.st = (i == 0);
        e.sp = (i == len - 1);
        e.fl = (i < nf);
        e.cr = (i >= nm);
        e.sz = (r >= cm);
        e.len = 13'(len);
`ifdef CB_CRC_ATTACH_EN
        e.d = (i < nm) ? m[i] : v[i];
`else
        e.d = (i < nm) ? m[i] : 1'b0;
`endif
        q.push_back(e);
      end
      n += nm - nf;
    end

    @(posedge clk); #1;
    tb_size_in = 17'(b);
    wreq_size = 1'b1;
    @(negedge clk);
    chk("size_ready_pre", size_ready, 1);
    @(posedge clk); #1;
    wreq_size = 1'b0;
    idx = 0;
    got = 0;
    cyc = 0;
    budget = 4 * q.size() + 200;
    while (q.size() > 0 && cyc < budget) begin
      wreq_data = stall ? ($urandom_range(0, 7) != 0) : 1'b1;
      cb_ready = stall ? ($urandom_range(0, 7) != 0) : 1'b1;
      tb_in = (idx < b) ? tbits[idx] : 1'($urandom_range(0, 1));
      wreq_size = ($urandom_range(0, 15) == 0);
      tb_size_in = 17'($urandom);
      @(negedge clk);
      if (cb_valid && cb_ready) begin
        act = {cb_data, start, stop, filling, crc, cb_size, cb_len};
        chk("beat", act, q[0]);
        if (start) chk("cb_num", cb_num, c);
        if (wreq_data && tb_ready) idx++;
        void'(q.pop_front());
        got++;
        if (abort_at > 0 && got == abort_at) break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    wreq_size = 1'b0;
    wreq_data = 1'b0;
    cb_ready = 1'b0;
    if (abort_at > 0) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", cb_valid, 0);
      chk("rst_size_ready", size_ready, 1);
    end else begin
      chk("budget_left", q.size(), 0);
      @(negedge clk);
      chk("done_busy", busy, 0);
      chk("done_size_ready", size_ready, 1);
      if (q.size() > 0) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    int c, kp, km, cp, cm, f;
    rst_n = 1'b0;
    tb_size_in = '0;
    wreq_size = 1'b0;
    tb_in = 1'b0;
    wreq_data = 1'b0;
    cb_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_size_ready", size_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cb_valid", cb_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_tb_ready", tb_ready, 0);
    chk("rst_flags", {start, stop, filling, crc, cb_size, cb_data}, 0);
    chk("rst_cb_len", cb_len, 0);
    chk("rst_cb_num", cb_num, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    seg(6145, c, kp, km, cp, cm, f);
    chk("pin6145_c", c, 2);
    chk("pin6145_kp", kp, 3136);
    chk("pin6145_km", km, 3072);
    chk("pin6145_cm", cm, 1);
    chk("pin6145_f", f, 15);
    seg(6144, c, kp, km, cp, cm, f);
    chk("pin6144_c", c, 1);
    chk("pin6144_kp", kp, 6144);
    chk("pin6144_f", f, 0);
    seg(20, c, kp, km, cp, cm, f);
    chk("pin20_kp", kp, 40);
    chk("pin20_f", f, 20);
    seg(100, c, kp, km, cp, cm, f);
    chk("pin100_kp", kp, 104);
    chk("pin100_f", f, 4);

    tb_size_in = '0;
    wreq_size = 1'b1;
    @(posedge clk); #1;
    wreq_size = 1'b0;
    @(negedge clk);
    chk("zero_err", err, 1);
    chk("zero_size_ready", size_ready, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_err_pulse", err, 0);

    run_tb(6144, 1'b0, 0);
    run_tb(6145, 1'b1, 0);
    run_tb(20, 1'b1, 0);
    run_tb(100, 1'b0, 0);
    run_tb(6145, 1'b1, 3572);
    run_tb(40, 1'b1, 0);
    repeat (3) run_tb(int'($urandom_range(1, 7000)), 1'b1, 0);
    run_tb(int'($urandom_range(12241, 13000)), 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
